debounce_toggle_gen: RTL
========================

DEBOUNCE_TOGGLE_GEN -- requirements
Module: debounce_toggle_gen

Upstream stage for the toggle flip-flop. Turns a raw, bouncing push-button input into a clean debounced level and single-cycle edge pulses. t_pulse drives the toggle stage's t input directly.

Interface
REQ-001 SHALL have parameter CNT_MAX, default 4: number of consecutive stable synchronized samples required to accept a transition; legal range 2 to 2^CNT_W.
REQ-002 SHALL have parameter CNT_W, default 16: debounce counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port btn_in  input  1  raw asynchronous button level.
REQ-006 SHALL have port btn_level  output  1  debounced button level, registered.
REQ-007 SHALL have port t_pulse  output  1  one-cycle pulse on an accepted 0->1 transition, registered; feeds the toggle stage.
REQ-008 SHALL have port fall_pulse  output  1  one-cycle pulse on an accepted 1->0 transition, registered.
REQ-009 SHALL have port busy  output  1  high while a candidate transition is being qualified.

Function
REQ-010 SHALL pass btn_in through a 2-flop synchronizer (s1, s2); only s2 ("s") SHALL be used by the FSM.
REQ-011 SHALL implement FSM states IDLE_LO, CHK_HI, IDLE_HI, CHK_LO.
REQ-012 IDLE_LO: s=1 -> CHK_HI with cnt=0; otherwise hold.
REQ-013 CHK_HI: s=0 -> IDLE_LO, glitch rejected, no output change.
REQ-014 CHK_HI: s=1 and cnt<CNT_MAX-1 -> cnt+1, stay in CHK_HI.
REQ-015 CHK_HI: s=1 and cnt=CNT_MAX-1 -> IDLE_HI, btn_level<=1, t_pulse<=1.
REQ-016 IDLE_HI, CHK_LO SHALL mirror IDLE_LO, CHK_HI with inverted polarity; acceptance sets btn_level<=0, fall_pulse<=1.
REQ-017 t_pulse and fall_pulse SHALL be high for exactly one cycle per accepted transition and SHALL never be high simultaneously.
REQ-018 Latency: for btn_in held stable from the first edge that samples the new value (edge 1), btn_level SHALL change and the pulse SHALL assert after edge CNT_MAX+3.
REQ-019 Any bounce during qualification SHALL restart qualification from the next stable sample; latency is then measured from the last change.
REQ-020 cnt SHALL never wrap; cnt SHALL be cleared to 0 on every entry to CHK_HI or CHK_LO.
REQ-021 busy SHALL be high exactly when state is CHK_HI or CHK_LO.

Reset
REQ-022 rst SHALL take priority over all other logic in the cycle it is sampled.
REQ-023 On rst: state=IDLE_LO, s1=s2=0, cnt=0, btn_level=0, t_pulse=0, fall_pulse=0, busy=0.
REQ-024 Reset during CHK_HI SHALL abort qualification and SHALL produce no t_pulse.
REQ-025 Reset while btn_level=1 SHALL clear btn_level and SHALL produce no fall_pulse.
REQ-026 btn_in held at 1 through reset release SHALL be qualified normally, producing one t_pulse CNT_MAX+3 edges after release.

Verification (CNT_MAX=4)
REQ-027 Reset: rst=1 for 2 cycles with btn_in=1 -> all outputs 0 during reset; after release, t_pulse=1 for one cycle at edge 7 and btn_level=1 from then on.
REQ-028 Clean press: btn_in 0->1 held 20 cycles -> btn_level rises after edge 7; exactly one t_pulse; fall_pulse stays 0.
REQ-029 Glitch: btn_in=1 for 3 cycles, then 0 -> btn_level stays 0; no pulses; busy high for the intermediate cycles, then 0.
REQ-030 Bounce: btn_in 1,0,1,0,1 (1 cycle each), then steady 1 -> exactly one t_pulse, 7 edges after the final 0->1.
REQ-031 Release: from btn_level=1, btn_in->0 held -> fall_pulse one cycle after edge 7; btn_level=0; t_pulse stays 0.
REQ-032 Reset mid-check: rst asserted in CHK_HI at cnt=2 -> no t_pulse, busy=0 next cycle; chained toggle stage output unchanged.

Source files
------------

// File: rtl/debounce_toggle_gen.sv
// Push-button debouncer: 2-flop synchronizer feeding a four-state qualifier
// that emits a clean level plus one-cycle rise (t_pulse) and fall pulses.
module debounce_toggle_gen #(
  parameter int CNT_MAX = 4,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic t_pulse,
  output logic fall_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  // Last count value; reaching it with a stable sample accepts the transition.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_t_pulse;
  logic             w_t_pulse_nxt;
  logic             r_fall_pulse;
  logic             w_fall_pulse_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  // Qualification next-state, counter and output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_level_nxt      = r_level;
    w_t_pulse_nxt    = 1'b0;
    w_fall_pulse_nxt = 1'b0;
    case (r_state)
      IDLE_LO: begin
        if (r_s2) begin
          w_state_nxt = CHK_HI;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = IDLE_LO;
        end
      end
      CHK_HI: begin
        if (!r_s2) begin
          w_state_nxt = IDLE_LO;
        end else if (r_cnt < CNT_LAST) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_state_nxt   = IDLE_HI;
          w_level_nxt   = 1'b1;
          w_t_pulse_nxt = 1'b1;
        end
      end
      IDLE_HI: begin
        if (!r_s2) begin
          w_state_nxt = CHK_LO;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = IDLE_HI;
        end
      end
      CHK_LO: begin
        if (r_s2) begin
          w_state_nxt = IDLE_HI;
        end else if (r_cnt < CNT_LAST) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_state_nxt      = IDLE_LO;
          w_level_nxt      = 1'b0;
          w_fall_pulse_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE_LO;
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_level_nxt = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt == CHK_HI) || (w_state_nxt == CHK_LO);
  end

  // State, synchronizer and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE_LO;
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_cnt        <= {CNT_W{1'b0}};
      r_level      <= 1'b0;
      r_t_pulse    <= 1'b0;
      r_fall_pulse <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_s1         <= btn_in;
      r_s2         <= r_s1;
      r_cnt        <= w_cnt_nxt;
      r_level      <= w_level_nxt;
      r_t_pulse    <= w_t_pulse_nxt;
      r_fall_pulse <= w_fall_pulse_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign btn_level  = r_level;
  assign t_pulse    = r_t_pulse;
  assign fall_pulse = r_fall_pulse;
  assign busy       = r_busy;

endmodule
